pico_rom_axil_bridge: RTL and testbench
=======================================

// Module: pico_rom_axil_bridge
// PURPOSE
//  AXI4-Lite slave to Avalon-MM master bridge. It sits directly upstream of the on-chip
//  firmware ROM (4096x32 single-port altsyncram, unregistered q, 1-cycle read latency).
//  It lets the AXI-Lite interconnect fetch firmware words. It can optionally patch them
//  through the ROM's debugaccess-gated write path.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte base of ROM window; must be aligned to 4*DEPTH
//  ADDR_W     12             ROM word-address width; DEPTH = 2**ADDR_W words
//  WRITABLE   0              1: AXI writes reach ROM with debugaccess=1; 0: writes rejected
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous active-high reset
//  s_awaddr       in   32  write byte address
//  s_awvalid/awready  in/out  1  AW handshake
//  s_wdata        in   32  write data
//  s_wstrb        in   4   byte strobes
//  s_wvalid/wready    in/out  1  W handshake
//  s_bresp        out  2   00 OKAY, 10 SLVERR, 11 DECERR
//  s_bvalid/bready    out/in  1  B handshake
//  s_araddr       in   32  read byte address
//  s_arvalid/arready  in/out  1  AR handshake
//  s_rdata        out  32  read data (registered)
//  s_rresp        out  2   as s_bresp
//  s_rvalid/rready    out/in  1  R handshake
//  avm_address    out  ADDR_W  ROM word address
//  avm_byteenable out  4   byte enables
//  avm_chipselect out  1   ROM access strobe
//  avm_write      out  1   write strobe
//  avm_debugaccess out 1   ROM write qualifier
//  avm_writedata  out  32  write data
//  avm_readdata   in   32  ROM q; valid the cycle after the chipselect cycle
// BEHAVIOUR
//  Reset: all handshake outputs 0; avm_* strobes 0; s_rdata 0; s_rresp/s_bresp 00; FSM=IDLE; last_grant=WR.
//  Decode: hit when addr[31:ADDR_W+2]==BASE_ADDR[31:ADDR_W+2]. Word index = addr[ADDR_W+1:2]. addr[1:0] is ignored.
//  FSM states: IDLE, RD_CS, RD_CAP, RD_RESP, WR_CS, WR_RESP. One transaction is in flight at a time.
//  IDLE:
//   - s_arready=1 only when a read is granted.
//   - s_awready=s_wready=1 together, only when awvalid&wvalid and a write is granted.
//     AW alone or W alone is never accepted.
//   - Arbitration is round-robin: if a read and a full write are both pending, grant the opposite of last_grant.
//   - Otherwise grant whichever is pending.
//  Read, handshake in cycle T:
//   - hit: T+1 RD_CS with chipselect=1, byteenable=4'hF, write=0. T+2 RD_CAP captures avm_readdata into s_rdata.
//     T+3 RD_RESP with rvalid=1, rresp=OKAY.
//   - miss: no avalon strobe; s_rdata=0, rresp=DECERR; rvalid=1 at T+1.
//  Write, handshake in cycle T:
//   - hit & WRITABLE: T+1 WR_CS with chipselect=write=debugaccess=1, byteenable=wstrb, writedata=wdata.
//     bvalid=1 at T+2 with bresp=OKAY.
//   - hit & !WRITABLE: no strobe; bvalid=1 at T+1 with bresp=SLVERR.
//   - miss: no strobe; bvalid=1 at T+1 with bresp=DECERR.
//   - wstrb==0 on a hit still performs a zero-byte Avalon write and returns OKAY.
//  Response hold:
//   - rvalid/bvalid, rdata and resp stay stable until rready/bready.
//   - Return to IDLE on the handshake cycle; the next AR/AW is accepted no earlier than the following cycle.
//  Strobes: chipselect, write and debugaccess are single-cycle pulses and are never asserted outside RD_CS/WR_CS.
//   debugaccess is 0 whenever write is 0.
//  Throughput: max one read per 4 cycles and one write per 3 cycles with ready held high.
//  Reset mid-transaction: reset in any state returns to IDLE next cycle with all outputs at reset values.
//   The pending response is dropped; no Avalon strobe follows the reset cycle.
// TESTING
//  1. Preload ROM[5]=32'hDEADBEEF, read araddr=BASE+0x14 with rready=1
//     -> chipselect 1 cycle with address=5; rvalid 3 cycles after AR handshake; rdata=DEADBEEF, rresp=00.
//  2. araddr=BASE+0x4000 (ADDR_W=12) -> no chipselect; rvalid next cycle; rdata=0, rresp=11.
//  3. WRITABLE=1, write 0x20 data=0x11223344 wstrb=4'b0011, then read 0x20
//     -> byteenable=0011, debugaccess=1; bresp=00; read returns old[31:16],16'h3344.
//     With WRITABLE=0 -> no write strobe; bresp=10.
//  4. AW valid without W for 10 cycles -> awready stays 0; then W arrives -> both readies in the same cycle.
//  5. AR and AW+W asserted continuously for 8 transactions -> grants strictly alternate; no strobe overlaps.
//     rready held 0 for 5 cycles -> rvalid/rdata stable.
//  6. Reset asserted in RD_CAP -> rvalid never asserts; FSM IDLE; next read completes correctly.

Source files
------------

// File: rtl/pico_rom_axil_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge in front of the firmware ROM.
// One transaction in flight; round-robin between reads and full writes.
module pico_rom_axil_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 12,
    parameter bit          WRITABLE  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [31:0]       s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_debugaccess,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);

    localparam int HI = ADDR_W + 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_CS,
        RD_CAP,
        RD_RESP,
        WR_CS,
        WR_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_last_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic [1:0]        r_bresp;

    logic w_ar_hit;
    logic w_aw_hit;
    logic w_rd_req;
    logic w_wr_req;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_unused;

    assign w_ar_hit = (s_araddr[31:HI] == BASE_ADDR[31:HI]);
    assign w_aw_hit = (s_awaddr[31:HI] == BASE_ADDR[31:HI]);
    assign w_rd_req = s_arvalid;
    assign w_wr_req = s_awvalid & s_wvalid;
    assign w_unused = ^{s_araddr[1:0], s_awaddr[1:0]};

    assign s_rdata         = r_rdata;
    assign s_rresp         = r_rresp;
    assign s_bresp         = r_bresp;
    assign avm_address     = r_addr;
    assign avm_writedata   = r_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Arbitration, next state and state-decoded handshake/strobe outputs
    always_comb begin
        w_next          = r_state;
        w_grant_rd      = 1'b0;
        w_grant_wr      = 1'b0;
        s_arready       = 1'b0;
        s_awready       = 1'b0;
        s_wready        = 1'b0;
        s_rvalid        = 1'b0;
        s_bvalid        = 1'b0;
        avm_chipselect  = 1'b0;
        avm_write       = 1'b0;
        avm_debugaccess = 1'b0;
        avm_byteenable  = 4'h0;
        unique case (r_state)
            IDLE: begin
                if (!reset) begin
                    if (w_rd_req && w_wr_req) begin
                        w_grant_rd = r_last_wr;
                        w_grant_wr = ~r_last_wr;
                    end else begin
                        w_grant_rd = w_rd_req;
                        w_grant_wr = w_wr_req;
                    end
                end
                s_arready = w_grant_rd;
                s_awready = w_grant_wr;
                s_wready  = w_grant_wr;
                if (w_grant_rd) begin
                    w_next = w_ar_hit ? RD_CS : RD_RESP;
                end else if (w_grant_wr) begin
                    w_next = (w_aw_hit && WRITABLE) ? WR_CS : WR_RESP;
                end
            end
            RD_CS: begin
                avm_chipselect = 1'b1;
                avm_byteenable = 4'hF;
                w_next         = RD_CAP;
            end
            RD_CAP: begin
                w_next = RD_RESP;
            end
            RD_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    w_next = IDLE;
                end
            end
            WR_CS: begin
                avm_chipselect  = 1'b1;
                avm_write       = 1'b1;
                avm_debugaccess = 1'b1;
                avm_byteenable  = r_wstrb;
                w_next          = WR_RESP;
            end
            WR_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture request fields at grant, read data in RD_CAP, track last grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_wr <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_grant_rd) begin
                r_last_wr <= 1'b0;
                r_addr    <= s_araddr[HI-1:2];
                r_rdata   <= '0;
                r_rresp   <= w_ar_hit ? RESP_OKAY : RESP_DECERR;
            end else if (w_grant_wr) begin
                r_last_wr <= 1'b1;
                r_addr    <= s_awaddr[HI-1:2];
                r_wdata   <= s_wdata;
                r_wstrb   <= s_wstrb;
                if (!w_aw_hit) begin
                    r_bresp <= RESP_DECERR;
                end else if (WRITABLE) begin
                    r_bresp <= RESP_OKAY;
                end else begin
                    r_bresp <= RESP_SLVERR;
                end
            end
            if (r_state == RD_CAP) begin
                r_rdata <= avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_pico_rom_axil_bridge.sv
// Directed bench for pico_rom_axil_bridge with a behavioural ROM and
// response scoreboard; a second read-only instance covers SLVERR.
module tb_pico_rom_axil_bridge;

    localparam logic [17:0] BASE_HI = 18'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 1;
    logic        s_arvalid = 0, s_rready = 1;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect, avm_write, avm_debugaccess;
    logic [31:0] avm_writedata, avm_readdata;

    logic [31:0] n_awaddr = '0, n_wdata = '0;
    logic [3:0]  n_wstrb = '0;
    logic        n_awvalid = 0, n_wvalid = 0;
    logic        n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
    logic [1:0]  n_bresp, n_rresp;
    logic [31:0] n_rdata;
    logic [11:0] n_avm_address;
    logic [3:0]  n_avm_byteenable;
    logic        n_avm_chipselect, n_avm_write, n_avm_debugaccess;
    logic [31:0] n_avm_writedata;
    logic [31:0] n_zero32 = '0;
    logic [31:0] n_araddr = '0;
    logic        n_arvalid = 0, n_rready = 1, n_bready = 1;

    pico_rom_axil_bridge #(.BASE_ADDR(32'h0), .ADDR_W(12), .WRITABLE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_debugaccess(avm_debugaccess), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    pico_rom_axil_bridge #(.BASE_ADDR(32'h0), .ADDR_W(12), .WRITABLE(1'b0)) u_ro (
        .clk(clk), .reset(reset),
        .s_awaddr(n_awaddr), .s_awvalid(n_awvalid), .s_awready(n_awready),
        .s_wdata(n_wdata), .s_wstrb(n_wstrb), .s_wvalid(n_wvalid), .s_wready(n_wready),
        .s_bresp(n_bresp), .s_bvalid(n_bvalid), .s_bready(n_bready),
        .s_araddr(n_araddr), .s_arvalid(n_arvalid), .s_arready(n_arready),
        .s_rdata(n_rdata), .s_rresp(n_rresp), .s_rvalid(n_rvalid), .s_rready(n_rready),
        .avm_address(n_avm_address), .avm_byteenable(n_avm_byteenable),
        .avm_chipselect(n_avm_chipselect), .avm_write(n_avm_write),
        .avm_debugaccess(n_avm_debugaccess), .avm_writedata(n_avm_writedata),
        .avm_readdata(n_zero32)
    );

    // ROM environment: registered address, q one cycle after chipselect
    logic [31:0] rom [4096];
    logic [31:0] rom_q = '0;
    assign avm_readdata = rom_q;
    always @(posedge clk) begin
        if (avm_chipselect) rom_q <= rom[avm_address];
        if (avm_chipselect && avm_write && avm_debugaccess)
            for (int b = 0; b < 4; b++)
                if (avm_byteenable[b]) rom[avm_address][8*b +: 8] = avm_writedata[8*b +: 8];
    end

    logic [31:0] exp_mem [4096];
    logic [33:0] rq[$];
    logic [1:0]  bq[$];

    int          cs_cnt = 0;
    int          n_cs_cnt = 0;
    logic [11:0] last_cs_addr = '0;
    logic [3:0]  last_be = '0;
    logic        last_dbg = 0;
    logic [31:0] last_wd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor and scoreboard: push at request handshake, pop at response
    always @(negedge clk) begin
        logic [33:0] e;
        logic [1:0]  eb;
        if (avm_chipselect) begin
            cs_cnt++;
            last_cs_addr = avm_address;
            if (avm_write) begin
                last_be  = avm_byteenable;
                last_dbg = avm_debugaccess;
                last_wd  = avm_writedata;
            end
        end
        if (n_avm_chipselect || n_avm_write) n_cs_cnt++;
        if (avm_debugaccess) chk("dbg_without_write", avm_write, 1);
        if (avm_write) chk("write_without_cs", avm_chipselect, 1);
        if (s_arready) chk("dual_grant", s_awready, 0);
        if (reset) begin
            rq.delete();
            bq.delete();
        end else begin
            if (s_arvalid && s_arready) begin
                if (s_araddr[31:14] == BASE_HI) rq.push_back({exp_mem[s_araddr[13:2]], 2'b00});
                else rq.push_back({32'h0, 2'b11});
            end
            if (s_awvalid && s_awready) begin
                if (s_awaddr[31:14] == BASE_HI) begin
                    bq.push_back(2'b00);
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) exp_mem[s_awaddr[13:2]][8*b +: 8] = s_wdata[8*b +: 8];
                end else begin
                    bq.push_back(2'b11);
                end
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) chk("r_unexpected", s_rvalid, 0);
                else begin
                    e = rq.pop_front();
                    chk("rdata", s_rdata, e[33:2]);
                    chk("rresp", s_rresp, e[1:0]);
                end
            end
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) chk("b_unexpected", s_bvalid, 0);
                else begin
                    eb = bq.pop_front();
                    chk("bresp", s_bresp, eb);
                end
            end
        end
    end

    task automatic rd(input logic [31:0] a, input int lat, input int ncs);
        int t0, cs0, n;
        @(posedge clk); #1;
        s_araddr = a; s_arvalid = 1;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_handshake", s_arready, 1);
        t0 = cyc; cs0 = cs_cnt;
        @(posedge clk); #1;
        s_arvalid = 0;
        n = 0;
        @(negedge clk);
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rd_latency", cyc - t0, lat);
        chk("rd_cs_count", cs_cnt - cs0, ncs);
        if (ncs > 0) chk("rd_cs_addr", last_cs_addr, a[13:2]);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      input int lat, input int ncs);
        int t0, cs0, n;
        @(posedge clk); #1;
        s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1; s_wvalid = 1;
        n = 0;
        @(negedge clk);
        while (!s_awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_handshake", s_awready, 1);
        chk("w_handshake", s_wready, 1);
        t0 = cyc; cs0 = cs_cnt;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        n = 0;
        @(negedge clk);
        while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
        chk("wr_latency", cyc - t0, lat);
        chk("wr_cs_count", cs_cnt - cs0, ncs);
        if (ncs > 0) begin
            chk("wr_byteenable", last_be, st);
            chk("wr_debugaccess", last_dbg, 1);
            chk("wr_writedata", last_wd, d);
            chk("wr_addr", last_cs_addr, a[13:2]);
        end
    endtask

    initial begin
        int n, ng, cs0;
        bit g, prev;
        logic [31:0] hold_d;
        for (int i = 0; i < 4096; i++) begin
            rom[i]     = (i * 32'h0101_0101) ^ 32'h5A00_0000;
            exp_mem[i] = (i * 32'h0101_0101) ^ 32'h5A00_0000;
        end
        rom[5] = 32'hDEAD_BEEF;  exp_mem[5] = 32'hDEAD_BEEF;
        rom[8] = 32'hA5A5_5A5A;  exp_mem[8] = 32'hA5A5_5A5A;

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_arready", s_arready, 0);
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_rresp", s_rresp, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_dbg", avm_debugaccess, 0);

        rd(32'h0000_0014, 3, 1);
        rd(32'h0000_4000, 1, 0);
        rd(32'h0000_0017, 3, 1);
        wr(32'h0000_0020, 32'h1122_3344, 4'b0011, 2, 1);
        rd(32'h0000_0020, 3, 1);
        wr(32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 2, 1);
        rd(32'h0000_0020, 3, 1);
        wr(32'h0000_4020, 32'h5555_5555, 4'hF, 1, 0);
        rd(32'h0000_0020, 3, 1);

        @(posedge clk); #1;
        n_awaddr = 32'h20; n_wdata = 32'h1122_3344; n_wstrb = 4'hF;
        n_awvalid = 1; n_wvalid = 1;
        @(negedge clk);
        chk("ro_awready", n_awready, 1);
        chk("ro_wready", n_wready, 1);
        @(posedge clk); #1;
        n_awvalid = 0; n_wvalid = 0;
        @(negedge clk);
        chk("ro_bvalid", n_bvalid, 1);
        chk("ro_bresp", n_bresp, 2'b10);

        @(posedge clk); #1;
        s_awaddr = 32'h30; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_awvalid = 1;
        repeat (10) begin
            @(negedge clk);
            chk("aw_only_awready", s_awready, 0);
            chk("aw_only_wready", s_wready, 0);
        end
        @(posedge clk); #1;
        s_wvalid = 1;
        @(negedge clk);
        chk("aw_w_awready", s_awready, 1);
        chk("aw_w_wready", s_wready, 1);
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        repeat (3) @(negedge clk);
        rd(32'h0000_0030, 3, 1);

        cs0 = cs_cnt;
        @(posedge clk); #1;
        s_araddr = 32'h14; s_arvalid = 1;
        s_awaddr = 32'h190; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        ng = 0; n = 0; prev = 0;
        while (ng < 8 && n < 200) begin
            @(negedge clk);
            n++;
            if (s_arready || s_awready) begin
                g = s_awready;
                if (ng > 0) chk("rr_alternate", g, !prev);
                prev = g;
                ng++;
            end
        end
        chk("rr_grants", ng, 8);
        @(posedge clk); #1;
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
        repeat (6) @(negedge clk);
        chk("rr_cs_count", cs_cnt - cs0, 8);
        chk("rr_rq_drained", rq.size(), 0);
        chk("rr_bq_drained", bq.size(), 0);

        @(posedge clk); #1;
        s_rready = 0; s_araddr = 32'h14; s_arvalid = 1;
        @(negedge clk);
        chk("hold_ar", s_arready, 1);
        @(posedge clk); #1;
        s_arvalid = 0;
        n = 0;
        @(negedge clk);
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        hold_d = s_rdata;
        repeat (5) begin
            @(negedge clk);
            chk("hold_rvalid", s_rvalid, 1);
            chk("hold_rdata", s_rdata, hold_d);
        end
        @(posedge clk); #1;
        s_rready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_release", s_rvalid, 0);

        @(posedge clk); #1;
        s_araddr = 32'h14; s_arvalid = 1;
        @(negedge clk);
        chk("rst_mid_ar", s_arready, 1);
        @(posedge clk); #1;
        s_arvalid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_rvalid", s_rvalid, 0);
            chk("rst_mid_cs", avm_chipselect, 0);
        end
        chk("rst_mid_rdata", s_rdata, 0);
        rd(32'h0000_0014, 3, 1);
        repeat (2) @(negedge clk);
        chk("ro_no_strobe", n_cs_cnt, 0);
        chk("final_rq", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
